// File: rtl/spi_pkg.sv
// Shared constants and helpers for the oversampled SPI target.
package spi_pkg;

   localparam logic [0:0] STATE_IDLE  = 1'b0;
   localparam logic [0:0] STATE_SHIFT = 1'b1;

   localparam int unsigned SPI_MAX_DATALENGTH = 32;

   // Bit counter must hold values 0..data_length.
   function automatic int unsigned cnt_width(input int unsigned data_length);
      return $clog2(data_length + 1);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser plus history flop; emits registered level and edge strobes.
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;

   // level is the history flop; strobes compare it against the last sync stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= {SYNC_STAGES{RESET_VALUE}};
         level <= RESET_VALUE;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], pin};
         level <= sync[SYNC_STAGES-1];
         rise  <= sync[SYNC_STAGES-1] & ~level;
         fall  <= ~sync[SYNC_STAGES-1] & level;
      end
   end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target, MSB first, oversampled in the clk domain; one parallel word per SPI word.
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned SPI_DATALENGTH = 32,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SPI_SCLK,
   input  logic        SPI_CS,
   input  logic        SPI_MOSI,
   output logic        SPI_MISO,
   output logic        SPI_MISO_OE,
   input  logic [31:0] sendData,
   output logic [31:0] recvData,
   output logic        recvValid,
   output logic        frameAbort
);

   localparam int unsigned WORD_W = SPI_MAX_DATALENGTH;
   localparam int unsigned CW     = cnt_width(SPI_DATALENGTH);
   localparam int unsigned ALIGN  = WORD_W - SPI_DATALENGTH;
   localparam logic [WORD_W-1:0] DATA_MASK =
      WORD_W'((64'(1) << SPI_DATALENGTH) - 64'(1));

   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic cs_rise, cs_fall, cs_level_unused;
   logic mosi_level, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sclk (
      .clk(clk), .rst(rst), .pin(SPI_SCLK),
      .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_cs (
      .clk(clk), .rst(rst), .pin(SPI_CS),
      .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .pin(SPI_MOSI),
      .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   logic [0:0]        state, state_nxt;
   logic [WORD_W-1:0] tx_shift, tx_nxt;
   logic [WORD_W-1:0] rx_shift, rx_nxt;
   logic [CW-1:0]     bit_cnt, cnt_nxt;
   logic              reload, reload_nxt;
   logic              miso_nxt, oe_nxt, valid_nxt, abort_nxt;
   logic [WORD_W-1:0] recv_nxt;
   logic [WORD_W-1:0] send_aligned_c;

   // Response word left-aligned so the MSB of the active width sits at bit 31
   assign send_aligned_c = (sendData & DATA_MASK) << ALIGN;

   always_comb begin
      state_nxt  = state;
      tx_nxt     = tx_shift;
      rx_nxt     = rx_shift;
      cnt_nxt    = bit_cnt;
      reload_nxt = reload;
      miso_nxt   = SPI_MISO;
      oe_nxt     = SPI_MISO_OE;
      recv_nxt   = recvData;
      valid_nxt  = 1'b0;
      abort_nxt  = 1'b0;
      case (state)
         STATE_IDLE: begin
            miso_nxt = 1'b0;
            oe_nxt   = 1'b0;
            if (cs_fall) begin
               tx_nxt     = send_aligned_c;
               miso_nxt   = send_aligned_c[WORD_W-1];
               oe_nxt     = 1'b1;
               cnt_nxt    = '0;
               reload_nxt = 1'b0;
               state_nxt  = STATE_SHIFT;
            end
         end
         STATE_SHIFT: begin
            // Deselect wins over any SCLK edge seen in the same cycle
            if (cs_rise) begin
               state_nxt = STATE_IDLE;
               oe_nxt    = 1'b0;
               miso_nxt  = 1'b0;
               abort_nxt = (bit_cnt != '0);
               cnt_nxt   = '0;
            end else if (sclk_rise) begin
               rx_nxt = {rx_shift[WORD_W-2:0], mosi_level};
               if (bit_cnt == CW'(SPI_DATALENGTH - 1)) begin
                  recv_nxt   = rx_nxt & DATA_MASK;
                  valid_nxt  = 1'b1;
                  cnt_nxt    = '0;
                  reload_nxt = 1'b1;
               end else begin
                  cnt_nxt = bit_cnt + CW'(1);
               end
            end else if (sclk_fall) begin
               if (reload) begin
                  tx_nxt     = send_aligned_c;
                  reload_nxt = 1'b0;
               end else begin
                  tx_nxt = tx_shift << 1;
               end
               miso_nxt = tx_nxt[WORD_W-1];
            end
         end
         default: state_nxt = STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= STATE_IDLE;
         tx_shift    <= '0;
         rx_shift    <= '0;
         bit_cnt     <= '0;
         reload      <= 1'b0;
         SPI_MISO    <= 1'b0;
         SPI_MISO_OE <= 1'b0;
         recvData    <= '0;
         recvValid   <= 1'b0;
         frameAbort  <= 1'b0;
      end else begin
         state       <= state_nxt;
         tx_shift    <= tx_nxt;
         rx_shift    <= rx_nxt;
         bit_cnt     <= cnt_nxt;
         reload      <= reload_nxt;
         SPI_MISO    <= miso_nxt;
         SPI_MISO_OE <= oe_nxt;
         recvData    <= recv_nxt;
         recvValid   <= valid_nxt;
         frameAbort  <= abort_nxt;
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a 32-bit and an 8-bit target driven by a behavioural mode-0 master.
module tb_spi_slave;

   localparam int unsigned SYNC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sclk, cs, mosi, miso, oe, rv, fa;
   logic [31:0] send_data [2];
   logic [31:0] recv_data [2];

   int compared   = 0;
   int mismatched = 0;
   int ab0 = 0, ab1 = 0;
   logic [31:0] rq0[$], rq1[$], exp_q[$];

   initial forever #5 clk = ~clk;

   spi_slave #(.SPI_DATALENGTH(32), .SYNC_STAGES(SYNC)) u_dut32 (
      .clk(clk), .rst(rst), .SPI_SCLK(sclk[0]), .SPI_CS(cs[0]), .SPI_MOSI(mosi[0]),
      .SPI_MISO(miso[0]), .SPI_MISO_OE(oe[0]), .sendData(send_data[0]),
      .recvData(recv_data[0]), .recvValid(rv[0]), .frameAbort(fa[0]));

   spi_slave #(.SPI_DATALENGTH(8), .SYNC_STAGES(SYNC)) u_dut8 (
      .clk(clk), .rst(rst), .SPI_SCLK(sclk[1]), .SPI_CS(cs[1]), .SPI_MOSI(mosi[1]),
      .SPI_MISO(miso[1]), .SPI_MISO_OE(oe[1]), .sendData(send_data[1]),
      .recvData(recv_data[1]), .recvValid(rv[1]), .frameAbort(fa[1]));

   // Collect every received word and abort pulse
   always @(negedge clk) begin
      if (rv[0]) rq0.push_back(recv_data[0]);
      if (rv[1]) rq1.push_back(recv_data[1]);
      if (fa[0]) ab0++;
      if (fa[1]) ab1++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare the words received by unit u against exp_q, then drain
   task automatic check_rx(input int u, input string tag);
      logic [31:0] got;
      check($sformatf("%s_count", tag), 64'(u == 0 ? rq0.size() : rq1.size()), 64'(exp_q.size()));
      foreach (exp_q[k]) begin
         got = 'x;
         if (u == 0 && rq0.size() > 0) got = rq0.pop_front();
         else if (u == 1 && rq1.size() > 0) got = rq1.pop_front();
         check($sformatf("%s_word%0d", tag, k), 64'(got), 64'(exp_q[k]));
      end
      rq0.delete();
      rq1.delete();
      exp_q.delete();
   endtask

   // Mode-0 master: nbits MSB-first from mo, half period h clk; optional
   // sendData change at bit chg_bit; stop_bits>0 leaves CS low after that many bits.
   task automatic frame(input int u, input int nbits, input logic [63:0] mo, input int h,
                        input int chg_bit, input logic [31:0] chg_val, input int stop_bits,
                        output logic [63:0] mi);
      int nb;
      nb = (stop_bits > 0) ? stop_bits : nbits;
      mi = '0;
      cs[u]   = 1'b0;
      mosi[u] = mo[nbits-1];
      repeat (h) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         if (i == chg_bit) send_data[u] = chg_val;
         sclk[u] = 1'b1;
         mi = {mi[62:0], miso[u]};
         if (i == 0) check("oe_active", 64'(oe[u]), 64'(1));
         repeat (h) @(negedge clk);
         sclk[u] = 1'b0;
         if (i + 1 < nbits) mosi[u] = mo[nbits-2-i];
         repeat (h) @(negedge clk);
      end
      if (stop_bits == 0) begin
         cs[u] = 1'b1;
         repeat (SYNC + 2) @(negedge clk);
         check("oe_release", 64'(oe[u]), 64'(0));
         repeat (10) @(negedge clk);
      end
   endtask

   initial begin
      logic [63:0] mi;
      logic [31:0] w, s, s2;
      logic [23:0] w3;
      int ab_before;

      rst  = 1'b1;
      sclk = '0;
      cs   = '1;
      mosi = '0;
      send_data[0] = '0;
      send_data[1] = '0;
      repeat (3) @(negedge clk);
      check("rst_miso", 64'(miso), 64'(0));
      check("rst_oe", 64'(oe), 64'(0));
      check("rst_recv0", 64'(recv_data[0]), 64'(0));
      check("rst_recv1", 64'(recv_data[1]), 64'(0));
      check("rst_valid_abort", 64'({rv, fa}), 64'(0));
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Plain 32-bit exchange at clk/16
      send_data[0] = 32'hA5C3_0F96;
      frame(0, 32, 64'h1234_5678, 8, -1, 32'h0, 0, mi);
      check("x32_miso", mi, 64'hA5C3_0F96);
      exp_q.push_back(32'h1234_5678);
      check_rx(0, "x32_rx");
      check("x32_recvdata", 64'(recv_data[0]), 64'h1234_5678);
      check("x32_no_abort", 64'(ab0), 64'(0));

      // Abort after 10 bits
      ab_before = ab0;
      frame(0, 10, 64'($urandom), 8, -1, 32'h0, 0, mi);
      check("abort_pulse", 64'(ab0 - ab_before), 64'(1));
      check_rx(0, "abort_rx");
      check("abort_keep", 64'(recv_data[0]), 64'h1234_5678);

      // Two words back-to-back under one CS, sendData swapped during word one
      ab_before = ab0;
      send_data[0] = 32'h1111_1111;
      frame(0, 64, {32'hDEAD_BEEF, 32'h0BAD_F00D}, 8, 10, 32'h2222_2222, 0, mi);
      check("b2b_miso", mi, {32'h1111_1111, 32'h2222_2222});
      exp_q.push_back(32'hDEAD_BEEF);
      exp_q.push_back(32'h0BAD_F00D);
      check_rx(0, "b2b_rx");
      check("b2b_no_abort", 64'(ab0 - ab_before), 64'(0));

      // sendData changes after 5 bits: word in flight unaffected
      s = $urandom;
      w = $urandom;
      send_data[0] = s;
      frame(0, 32, 64'(w), 8, 5, ~s, 0, mi);
      check("midchg_miso", mi, 64'(s));
      exp_q.push_back(w);
      check_rx(0, "midchg_rx");

      // Reset after 17 bits, then a fresh frame
      ab_before = ab0;
      send_data[0] = $urandom;
      frame(0, 32, 64'($urandom), 8, -1, 32'h0, 17, mi);
      rst = 1'b1;
      #1;
      check("rstmid_miso", 64'(miso[0]), 64'(0));
      check("rstmid_oe", 64'(oe[0]), 64'(0));
      check("rstmid_recv", 64'(recv_data[0]), 64'(0));
      check("rstmid_pulses", 64'({rv[0], fa[0]}), 64'(0));
      cs[0]   = 1'b1;
      sclk[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("rstmid_no_abort", 64'(ab0 - ab_before), 64'(0));
      rq0.delete();
      s = $urandom;
      send_data[0] = s;
      frame(0, 32, 64'h0000_0000_CAFE_0001, 8, -1, 32'h0, 0, mi);
      check("rstmid_after_miso", mi, 64'(s));
      exp_q.push_back(32'hCAFE_0001);
      check_rx(0, "rstmid_after_rx");

      // 8-bit target at the minimum clk/8 ratio
      send_data[1] = 32'h0000_00E7;
      frame(1, 8, 64'h3C, 4, -1, 32'h0, 0, mi);
      check("w8_miso", mi, 64'hE7);
      exp_q.push_back(32'h0000_003C);
      check_rx(1, "w8_rx");
      check("w8_recvdata", 64'(recv_data[1]), 64'h3C);

      // Random traffic against a slice-based reference
      for (int k = 0; k < 4; k++) begin
         w = $urandom;
         s = $urandom;
         send_data[0] = s;
         frame(0, 32, 64'(w), 8, -1, 32'h0, 0, mi);
         check($sformatf("rnd32_miso%0d", k), mi, 64'(s));
         exp_q.push_back(w);
         check_rx(0, $sformatf("rnd32_rx%0d", k));

         w3 = 24'($urandom);
         s2 = $urandom;
         send_data[1] = s2;
         frame(1, 24, 64'(w3), 4, -1, 32'h0, 0, mi);
         check($sformatf("rnd8_miso%0d", k), mi, 64'({s2[7:0], s2[7:0], s2[7:0]}));
         exp_q.push_back(32'(w3[23:16]));
         exp_q.push_back(32'(w3[15:8]));
         exp_q.push_back(32'(w3[7:0]));
         check_rx(1, $sformatf("rnd8_rx%0d", k));
      end
      check("abort8_none", 64'(ab1), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
